// File: rtl/strip_header_pkg.sv
// strip_header_pkg
// Shared types and constants for the strip_header receive stage.
//   fsm_state_t      : header/data phase of the input stream
//   HDR_LEN_W        : width of the length field carried in the header beat
//   BYTE_CNT_W       : width of the received-byte counter used by the length checker
//   byte_cnt_sat_add : saturating add for the byte counter
package strip_header_pkg;

    localparam int HDR_LEN_W  = 16;
    localparam int BYTE_CNT_W = 17;
    localparam int ERR_CNT_W  = 16;

    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = {BYTE_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0]  ERR_CNT_MAX  = {ERR_CNT_W{1'b1}};

    typedef enum logic [0:0] {
        FSM_WAIT_HDR  = 1'b0,
        FSM_PASS_DATA = 1'b1
    } fsm_state_t;

    function automatic logic [BYTE_CNT_W-1:0] byte_cnt_sat_add(
        input logic [BYTE_CNT_W-1:0] a,
        input logic [BYTE_CNT_W-1:0] b
    );
        logic [BYTE_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[BYTE_CNT_W]) begin
            return BYTE_CNT_MAX;
        end
        return sum[BYTE_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/strip_header_keep_popcount.sv
// keep_popcount
// Combinational count of set bits in an AXI-Stream tkeep vector.
// Ports:
//   i_keep  : byte enables, KW bits
//   o_count : number of enabled bytes, 0..KW
module keep_popcount #(
    parameter int KW    = 16,
    parameter int CNT_W = $clog2(KW + 1)
) (
    input  logic [KW-1:0]    i_keep,
    output logic [CNT_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < KW; i++) begin
            o_count = o_count + {{(CNT_W-1){1'b0}}, i_keep[i]};
        end
    end

endmodule

// File: rtl/strip_header.sv
// strip_header
// Removes the one-beat length header in front of every packet of an
// AXI-Stream. The packet data continues on axis_data_* with zero latency;
// the header length goes out on a separate one-entry axis_plen_* stream.
//
// Optional build macro: STRIP_HEADER_LEN_CHECK_EN
//   When defined, received bytes are counted per packet and compared with
//   the header length at tlast; mismatches pulse len_err and bump the
//   saturating err_count. When undefined, len_err and err_count are tied 0.
//
// Ports:
//   clk, resetn                : clock, async active-low reset
//   axis_in_*                  : header + packet input stream
//   axis_data_*                : packet data with header removed
//   axis_plen_tdata/tvalid/... : packet length, one entry per packet
//   len_err                    : one-cycle pulse on length mismatch
//   err_count                  : saturating mismatch count
//
// state         | meaning
// FSM_WAIT_HDR  | next input beat is a header; data output idle
// FSM_PASS_DATA | input beats are packet data, forwarded combinationally
module strip_header
    import strip_header_pkg::*;
#(
    parameter int DW = 128
) (
    input  logic                 clk,
    input  logic                 resetn,

    input  logic [DW-1:0]        axis_in_tdata,
    input  logic [DW/8-1:0]      axis_in_tkeep,
    input  logic                 axis_in_tlast,
    input  logic                 axis_in_tvalid,
    output logic                 axis_in_tready,

    output logic [DW-1:0]        axis_data_tdata,
    output logic [DW/8-1:0]      axis_data_tkeep,
    output logic                 axis_data_tlast,
    output logic                 axis_data_tvalid,
    input  logic                 axis_data_tready,

    output logic [HDR_LEN_W-1:0] axis_plen_tdata,
    output logic                 axis_plen_tvalid,
    input  logic                 axis_plen_tready,

    output logic                 len_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int KW = DW / 8;

    fsm_state_t           r_state;
    fsm_state_t           w_state_nxt;
    logic                 w_plen_free;
    logic                 w_hdr_acc;
    logic                 w_data_hs;
    logic                 r_plen_valid;
    logic [HDR_LEN_W-1:0] r_plen;

    // The plen slot only gates header acceptance, never packet data.
    assign w_plen_free = !r_plen_valid || axis_plen_tready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= FSM_WAIT_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are qualified by resetn so ready/data stay low while reset is held,
    // even if the plen consumer is ready.
    always_comb begin
        w_state_nxt      = r_state;
        axis_in_tready   = 1'b0;
        axis_data_tdata  = '0;
        axis_data_tkeep  = '0;
        axis_data_tlast  = 1'b0;
        axis_data_tvalid = 1'b0;
        w_hdr_acc        = 1'b0;
        w_data_hs        = 1'b0;
        if (resetn) begin
            case (r_state)
                FSM_WAIT_HDR: begin
                    axis_in_tready = w_plen_free;
                    w_hdr_acc      = axis_in_tvalid && w_plen_free;
                    // A header with tlast is a zero-length packet: stay put.
                    if (w_hdr_acc && !axis_in_tlast) begin
                        w_state_nxt = FSM_PASS_DATA;
                    end
                end
                FSM_PASS_DATA: begin
                    axis_data_tdata  = axis_in_tdata;
                    axis_data_tkeep  = axis_in_tkeep;
                    axis_data_tlast  = axis_in_tlast;
                    axis_data_tvalid = axis_in_tvalid;
                    axis_in_tready   = axis_data_tready;
                    w_data_hs        = axis_in_tvalid && axis_data_tready;
                    if (w_data_hs && axis_in_tlast) begin
                        w_state_nxt = FSM_WAIT_HDR;
                    end
                end
                default: begin
                    w_state_nxt = FSM_WAIT_HDR;
                end
            endcase
        end
    end

    // One-entry plen slot; a header accepted in the same cycle the slot
    // drains reloads it and keeps it valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_plen_valid <= 1'b0;
            r_plen       <= '0;
        end else if (w_hdr_acc) begin
            r_plen_valid <= 1'b1;
            r_plen       <= axis_in_tdata[HDR_LEN_W-1:0];
        end else if (r_plen_valid && axis_plen_tready) begin
            r_plen_valid <= 1'b0;
        end
    end

    assign axis_plen_tdata  = r_plen;
    assign axis_plen_tvalid = r_plen_valid;

`ifdef STRIP_HEADER_LEN_CHECK_EN
    localparam int KCW = $clog2(KW + 1);

    logic [KCW-1:0]        w_keep_cnt;
    logic [BYTE_CNT_W-1:0] w_cnt_sum;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [HDR_LEN_W-1:0]  r_hdr_len;
    logic                  r_len_err;
    logic [ERR_CNT_W-1:0]  r_err_count;

    keep_popcount #(
        .KW    (KW),
        .CNT_W (KCW)
    ) u_keep_popcount (
        .i_keep  (axis_in_tkeep),
        .o_count (w_keep_cnt)
    );

    assign w_cnt_sum = byte_cnt_sat_add(r_byte_cnt, BYTE_CNT_W'(w_keep_cnt));

    // Header length is latched separately from the plen slot so the compare
    // is independent of when the plen consumer drains.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_byte_cnt  <= '0;
            r_hdr_len   <= '0;
            r_len_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_len_err <= 1'b0;
            if (w_hdr_acc) begin
                r_hdr_len  <= axis_in_tdata[HDR_LEN_W-1:0];
                r_byte_cnt <= '0;
            end
            if (w_data_hs) begin
                if (axis_in_tlast) begin
                    r_byte_cnt <= '0;
                    if (w_cnt_sum != {1'b0, r_hdr_len}) begin
                        r_len_err <= 1'b1;
                        if (r_err_count != ERR_CNT_MAX) begin
                            r_err_count <= r_err_count + 1'b1;
                        end
                    end
                end else begin
                    r_byte_cnt <= w_cnt_sum;
                end
            end
        end
    end

    assign len_err   = r_len_err;
    assign err_count = r_err_count;
`else
    assign len_err   = 1'b0;
    assign err_count = '0;
`endif

endmodule
